// File: rtl/i2c_slave_ctrl_pkg.sv
// Shared FSM state encoding and bus constants for the I2C target controller.
package i2c_slave_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ADDRESS   = 4'd1,
        S_ADDR_ACK  = 4'd2,
        S_RX        = 4'd3,
        S_RX_ACK    = 4'd4,
        S_TX        = 4'd5,
        S_TX_ACK    = 4'd6,
        S_WAIT_STOP = 4'd7
    } state_t;

    localparam logic I2C_RW_READ = 1'b1;

endpackage

// File: rtl/i2c_slave_ctrl_if.sv
// Pad and user-side signals of the I2C target, grouped for the controller port list.
interface i2c_slave_ctrl_if;

    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       busy;
    logic       addr_match;

    modport slave (
        input  scl_in, sda_in, tx_data,
        output sda_oe, rx_data, rx_valid, tx_req, busy, addr_match
    );

    modport master (
        output scl_in, sda_in, tx_data,
        input  sda_oe, rx_data, rx_valid, tx_req, busy, addr_match
    );

endinterface

// File: rtl/i2c_slave_ctrl_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pad input plus one history flop
// producing single-cycle rise/fall strobes.
module i2c_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Reset to the idle bus level so leaving reset creates no spurious edges.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            hist_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  =  sync_q[SYNC_STAGES-1] & ~hist_q;
    assign fall_o  = ~sync_q[SYNC_STAGES-1] &  hist_q;

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C target controller: START/STOP detection, 7-bit address match, byte receive
// with ACK, and byte transmit with master ACK/NACK handling. Open-drain SDA only.
module i2c_slave_ctrl
    import i2c_slave_ctrl_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic              i2c_clk_in,
    input  logic              reset,
    i2c_slave_ctrl_if.slave   bus
);

    logic scl_hi, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_scl (
        .clk_i   (i2c_clk_in),
        .rst_i   (reset),
        .async_i (bus.scl_in),
        .level_o (scl_hi),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sda (
        .clk_i   (i2c_clk_in),
        .rst_i   (reset),
        .async_i (bus.sda_in),
        .level_o (sda_lvl),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       sda_oe_q, sda_oe_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       busy_q, busy_d;
    logic       addr_match_q, addr_match_d;

    always_ff @(posedge i2c_clk_in or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= 3'd7;
            shreg_q      <= 8'h00;
            rx_data_q    <= 8'h00;
            sda_oe_q     <= 1'b0;
            rx_valid_q   <= 1'b0;
            tx_req_q     <= 1'b0;
            busy_q       <= 1'b0;
            addr_match_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            rx_data_q    <= rx_data_d;
            sda_oe_q     <= sda_oe_d;
            rx_valid_q   <= rx_valid_d;
            tx_req_q     <= tx_req_d;
            busy_q       <= busy_d;
            addr_match_q <= addr_match_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        rx_data_d    = rx_data_q;
        sda_oe_d     = sda_oe_q;
        rx_valid_d   = 1'b0;
        tx_req_d     = 1'b0;
        busy_d       = busy_q;
        addr_match_d = addr_match_q;

        if (scl_hi && sda_rise) begin
            state_d      = S_IDLE;
            sda_oe_d     = 1'b0;
            busy_d       = 1'b0;
            addr_match_d = 1'b0;
        end else if (scl_hi && sda_fall) begin
            state_d      = S_ADDRESS;
            bit_cnt_d    = 3'd7;
            sda_oe_d     = 1'b0;
            busy_d       = 1'b1;
            addr_match_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: ;
                S_ADDRESS: if (scl_rise) begin
                    shreg_d = {shreg_q[6:0], sda_lvl};
                    if (bit_cnt_q == 3'd0) begin
                        bit_cnt_d = 3'd7;
                        if (shreg_d[7:1] == SLAVE_ADDR) begin
                            state_d      = S_ADDR_ACK;
                            addr_match_d = 1'b1;
                        end else begin
                            state_d = S_WAIT_STOP;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                    end
                end
                // sda_oe_q doubles as the phase flag: first fall starts the ACK, second ends it.
                S_ADDR_ACK: if (scl_fall) begin
                    if (!sda_oe_q) begin
                        sda_oe_d = 1'b1;
                    end else if (shreg_q[0] == I2C_RW_READ) begin
                        state_d   = S_TX;
                        shreg_d   = bus.tx_data;
                        tx_req_d  = 1'b1;
                        bit_cnt_d = 3'd7;
                        sda_oe_d  = ~bus.tx_data[7];
                    end else begin
                        state_d   = S_RX;
                        bit_cnt_d = 3'd7;
                        sda_oe_d  = 1'b0;
                    end
                end
                S_RX: if (scl_rise) begin
                    shreg_d = {shreg_q[6:0], sda_lvl};
                    if (bit_cnt_q == 3'd0) begin
                        state_d    = S_RX_ACK;
                        bit_cnt_d  = 3'd7;
                        rx_data_d  = shreg_d;
                        rx_valid_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                    end
                end
                S_RX_ACK: if (scl_fall) begin
                    if (!sda_oe_q) begin
                        sda_oe_d = 1'b1;
                    end else begin
                        sda_oe_d = 1'b0;
                        state_d  = S_RX;
                    end
                end
                S_TX: if (scl_fall) begin
                    if (bit_cnt_q == 3'd0) begin
                        state_d  = S_TX_ACK;
                        sda_oe_d = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        sda_oe_d  = ~shreg_q[bit_cnt_q - 3'd1];
                    end
                end
                // A NACK leaves on the rise, so any fall seen here follows an ACK.
                S_TX_ACK: begin
                    if (scl_rise && sda_lvl) begin
                        state_d = S_WAIT_STOP;
                    end else if (scl_fall) begin
                        state_d   = S_TX;
                        shreg_d   = bus.tx_data;
                        tx_req_d  = 1'b1;
                        bit_cnt_d = 3'd7;
                        sda_oe_d  = ~bus.tx_data[7];
                    end
                end
                S_WAIT_STOP: sda_oe_d = 1'b0;
                default: begin
                    state_d  = S_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    assign bus.sda_oe     = sda_oe_q;
    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.tx_req     = tx_req_q;
    assign bus.busy       = busy_q;
    assign bus.addr_match = addr_match_q;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Directed bench for i2c_slave_ctrl: a bit-banged I2C master on a wired-AND SDA line.
module tb_i2c_slave_ctrl;

    localparam int Q = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] tx_m = 8'h00;

    i2c_slave_ctrl_if bus ();

    wire sda_line = sda_m & ~bus.sda_oe;
    assign bus.scl_in  = scl_m;
    assign bus.sda_in  = sda_line;
    assign bus.tx_data = tx_m;

    i2c_slave_ctrl #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .i2c_clk_in (clk),
        .reset      (rst),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         rx_cnt = 0;
    int         tx_cnt = 0;
    int         oe_cnt = 0;
    int         am_cnt = 0;
    logic [7:0] rx_hist[$];

    always @(negedge clk) begin
        if (bus.rx_valid) begin
            rx_cnt++;
            rx_hist.push_back(bus.rx_data);
        end
        if (bus.tx_req)     tx_cnt++;
        if (bus.sda_oe)     oe_cnt++;
        if (bus.addr_match) am_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wclk(Q);
        scl_m = 1'b1; wclk(Q);
        sda_m = 1'b0; wclk(Q);
        scl_m = 1'b0; wclk(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wclk(Q);
        scl_m = 1'b1; wclk(Q);
        sda_m = 1'b1; wclk(Q);
    endtask

    task automatic xfer_bit(input logic b, output logic got);
        sda_m = b;    wclk(Q);
        scl_m = 1'b1; wclk(Q);
        got = sda_line; wclk(Q);
        scl_m = 1'b0; wclk(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack_line);
        logic g;
        for (int i = 7; i >= 0; i--) xfer_bit(b[i], g);
        xfer_bit(1'b1, ack_line);
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] b);
        logic g;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(1'b1, g);
            b[i] = g;
        end
        xfer_bit(master_ack, g);
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] tx;
        logic       exp_addr_line;
        logic       exp_data_line;
        int         exp_rx;
        logic [7:0] exp_rx_data;
        int         exp_tx;
        logic [7:0] exp_rd;
        logic       exp_quiet;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic       l;
        logic [7:0] r;
        int         rx0, tx0, oe0, am0;

        vecs[0] = '{8'hA0, 8'h3C, 8'h00, 1'b0, 1'b0, 1, 8'h3C, 0, 8'h00, 1'b0};
        vecs[1] = '{8'hA2, 8'hFF, 8'h00, 1'b1, 1'b1, 0, 8'h00, 0, 8'h00, 1'b1};
        vecs[2] = '{8'hA1, 8'h00, 8'h96, 1'b0, 1'b0, 0, 8'h00, 1, 8'h96, 1'b0};
        vecs[3] = '{8'hA0, 8'h00, 8'h00, 1'b0, 1'b0, 1, 8'h00, 0, 8'h00, 1'b0};
        vecs[4] = '{8'hA0, 8'h5A, 8'h00, 1'b0, 1'b0, 1, 8'h5A, 0, 8'h00, 1'b0};

        wclk(5);
        chk("reset_sda_oe",     {31'd0, bus.sda_oe},     32'd0);
        chk("reset_rx_data",    {24'd0, bus.rx_data},    32'd0);
        chk("reset_busy",       {31'd0, bus.busy},       32'd0);
        chk("reset_addr_match", {31'd0, bus.addr_match}, 32'd0);
        rst = 1'b0;
        wclk(10);

        for (int i = 0; i < 5; i++) begin
            rx0 = rx_cnt; tx0 = tx_cnt; oe0 = oe_cnt; am0 = am_cnt;
            tx_m = vecs[i].tx;
            i2c_start();
            chk($sformatf("v%0d_busy_start", i), {31'd0, bus.busy}, 32'd1);
            write_byte(vecs[i].addr, l);
            chk($sformatf("v%0d_addr_ack", i), {31'd0, l}, {31'd0, vecs[i].exp_addr_line});
            if (!vecs[i].addr[0]) begin
                write_byte(vecs[i].data, l);
                chk($sformatf("v%0d_data_ack", i), {31'd0, l}, {31'd0, vecs[i].exp_data_line});
            end else begin
                read_byte(1'b1, r);
                chk($sformatf("v%0d_read", i), {24'd0, r}, {24'd0, vecs[i].exp_rd});
            end
            i2c_stop();
            chk($sformatf("v%0d_busy_stop", i), {31'd0, bus.busy}, 32'd0);
            chk($sformatf("v%0d_am_stop", i), {31'd0, bus.addr_match}, 32'd0);
            chk($sformatf("v%0d_rx_cnt", i), rx_cnt - rx0, vecs[i].exp_rx);
            if (vecs[i].exp_rx > 0)
                chk($sformatf("v%0d_rx_data", i), {24'd0, bus.rx_data}, {24'd0, vecs[i].exp_rx_data});
            chk($sformatf("v%0d_tx_cnt", i), tx_cnt - tx0, vecs[i].exp_tx);
            if (vecs[i].exp_quiet) begin
                chk($sformatf("v%0d_oe_quiet", i), oe_cnt - oe0, 0);
                chk($sformatf("v%0d_am_quiet", i), am_cnt - am0, 0);
            end
        end

        // Read with master ACK: second byte fetched, then NACK parks the target.
        tx0 = tx_cnt;
        tx_m = 8'h96;
        i2c_start();
        write_byte(8'hA1, l);
        chk("rdack_addr_ack", {31'd0, l}, 32'd0);
        tx_m = 8'h3C;
        read_byte(1'b0, r);
        chk("rdack_byte0", {24'd0, r}, 32'h96);
        read_byte(1'b1, r);
        chk("rdack_byte1", {24'd0, r}, 32'h3C);
        chk("rdack_tx_cnt", tx_cnt - tx0, 2);
        oe0 = oe_cnt;
        xfer_bit(1'b1, l);
        chk("rdack_released", {31'd0, l}, 32'd1);
        chk("rdack_oe_idle", oe_cnt - oe0, 0);
        i2c_stop();

        // Repeated START in the middle of a write byte.
        rx0 = rx_cnt;
        tx_m = 8'hC3;
        i2c_start();
        write_byte(8'hA0, l);
        chk("rs_addr_ack", {31'd0, l}, 32'd0);
        xfer_bit(1'b1, l); xfer_bit(1'b0, l); xfer_bit(1'b1, l); xfer_bit(1'b0, l);
        i2c_start();
        chk("rs_am_cleared", {31'd0, bus.addr_match}, 32'd0);
        chk("rs_busy", {31'd0, bus.busy}, 32'd1);
        write_byte(8'hA1, l);
        chk("rs_read_ack", {31'd0, l}, 32'd0);
        read_byte(1'b1, r);
        chk("rs_read_byte", {24'd0, r}, 32'hC3);
        chk("rs_no_rx", rx_cnt - rx0, 0);
        i2c_stop();

        // Reset while the target pulls SDA low for a 0 data bit.
        tx_m = 8'h00;
        i2c_start();
        write_byte(8'hA1, l);
        chk("rst_pre_oe", {31'd0, bus.sda_oe}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_oe_now", {31'd0, bus.sda_oe}, 32'd0);
        chk("rst_busy_now", {31'd0, bus.busy}, 32'd0);
        wclk(3);
        rst = 1'b0;
        wclk(5);
        rx0 = rx_cnt;
        i2c_start();
        write_byte(8'hA0, l);
        chk("postrst_addr_ack", {31'd0, l}, 32'd0);
        write_byte(8'hA5, l);
        chk("postrst_data_ack", {31'd0, l}, 32'd0);
        i2c_stop();
        chk("postrst_rx_cnt", rx_cnt - rx0, 1);
        chk("postrst_rx_data", {24'd0, bus.rx_data}, 32'hA5);

        // Back-to-back bytes in one write transfer.
        rx0 = rx_cnt;
        i2c_start();
        write_byte(8'hA0, l);
        write_byte(8'h00, l);
        chk("b2b_ack0", {31'd0, l}, 32'd0);
        write_byte(8'hFF, l);
        chk("b2b_ack1", {31'd0, l}, 32'd0);
        write_byte(8'h5A, l);
        chk("b2b_ack2", {31'd0, l}, 32'd0);
        i2c_stop();
        chk("b2b_rx_cnt", rx_cnt - rx0, 3);
        if (rx_hist.size() >= rx0 + 3) begin
            chk("b2b_rx0", {24'd0, rx_hist[rx0]},   32'h00);
            chk("b2b_rx1", {24'd0, rx_hist[rx0+1]}, 32'hFF);
            chk("b2b_rx2", {24'd0, rx_hist[rx0+2]}, 32'h5A);
        end
        chk("b2b_busy", {31'd0, bus.busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
